// File: rtl/aes_last_round_pipe.sv
// Pipelined, back-pressurable AES last round (encrypt or decrypt per block) with a sideband tag.
// Optional feature macro AES_LR_SECURE_CLEAR_EN: zero every stage data/key/tag register whenever it empties.
module aes_last_round_pipe #(
    parameter int PIPE_STAGES = 3,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dec,
    input  logic [127:0]     in_state,
    input  logic [127:0]     in_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int DATA_W = 128;
    localparam int SHIFT_STAGE = (PIPE_STAGES >= 2) ? 1 : 0;
    // The key/dec of a block are only needed up to the stage that applies AddRoundKey.
    localparam int KD = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
        $error("aes_last_round_pipe: PIPE_STAGES must be 1..3");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] r;
        t = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] w;
        w = {a, a};
        return w[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = ginv(b);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [DATA_W-1:0] sub_layer(input logic [DATA_W-1:0] st, input logic dec);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int n = 0; n < 16; n++)
            res[8*n +: 8] = dec ? inv_sbox(st[8*n +: 8]) : sbox(st[8*n +: 8]);
        return res;
    endfunction

    // Byte (row, col) lives at [127-8*(row+4*col) -: 8].
    function automatic logic [DATA_W-1:0] shift_layer(input logic [DATA_W-1:0] st, input logic dec);
        logic [DATA_W-1:0] res;
        int src;
        res = '0;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                src = dec ? ((col - row + 4) % 4) : ((col + row) % 4);
                res[DATA_W-1-8*(row+4*col) -: 8] = st[DATA_W-1-8*(row+4*src) -: 8];
            end
        end
        return res;
    endfunction

    // Work done on the way into stage k; S-box and row shift commute, so one split serves both modes.
    function automatic logic [DATA_W-1:0] stage_op(input int k, input logic [DATA_W-1:0] st,
                                                   input logic [DATA_W-1:0] key, input logic dec);
        logic [DATA_W-1:0] res;
        res = st;
        if (k == 0) res = sub_layer(res, dec);
        if (k == SHIFT_STAGE) res = shift_layer(res, dec);
        if (k == PIPE_STAGES - 1) res = res ^ key;
        return res;
    endfunction

    logic [PIPE_STAGES-1:0] vld_q, vld_d, slot_free, load, src_vld;
    logic [DATA_W-1:0]      st_q [PIPE_STAGES];
    logic [DATA_W-1:0]      st_d [PIPE_STAGES];
    logic [DATA_W-1:0]      src_st [PIPE_STAGES];
    logic [DATA_W-1:0]      src_key [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] src_dec;
    logic [TAG_W-1:0]       tag_q [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_d [PIPE_STAGES];
    logic [TAG_W-1:0]       src_tag [PIPE_STAGES];
    logic [DATA_W-1:0]      key_q [KD];
    logic [DATA_W-1:0]      key_d [KD];
    logic [KD-1:0]          dec_q, dec_d;

    // A stage can take a new block if it is empty or its content moves on this edge.
    always_comb begin
        logic chain;
        chain     = out_ready;
        slot_free = '0;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            slot_free[k] = !vld_q[k] || chain;
            chain        = slot_free[k];
        end
    end

    always_comb begin
        src_vld[0] = in_valid;
        src_st[0]  = in_state;
        src_key[0] = in_key;
        src_dec[0] = in_dec;
        src_tag[0] = in_tag;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_st[k]  = st_q[k-1];
            src_key[k] = key_q[k-1];
            src_dec[k] = dec_q[k-1];
            src_tag[k] = tag_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
            load[k]  = slot_free[k] && src_vld[k] && !flush;
            vld_d[k] = flush ? 1'b0 : (slot_free[k] ? src_vld[k] : vld_q[k]);
            st_d[k]  = load[k] ? stage_op(k, src_st[k], src_key[k], src_dec[k]) : st_q[k];
            tag_d[k] = load[k] ? src_tag[k] : tag_q[k];
`ifdef AES_LR_SECURE_CLEAR_EN
            if (!vld_d[k]) begin
                st_d[k]  = '0;
                tag_d[k] = '0;
            end
`endif
        end
        for (int k = 0; k < KD; k++) begin
            key_d[k] = load[k] ? src_key[k] : key_q[k];
            dec_d[k] = load[k] ? src_dec[k] : dec_q[k];
`ifdef AES_LR_SECURE_CLEAR_EN
            if (!vld_d[k]) begin
                key_d[k] = '0;
                dec_d[k] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    // Data registers carry no reset; the output is masked by the valid bit instead.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
            st_q[k]  <= st_d[k];
            tag_q[k] <= tag_d[k];
        end
        for (int k = 0; k < KD; k++) begin
            key_q[k] <= key_d[k];
            dec_q[k] <= dec_d[k];
        end
    end

    assign in_ready  = slot_free[0] && !flush;
    assign out_valid = vld_q[PIPE_STAGES-1];
    assign out_state = vld_q[PIPE_STAGES-1] ? st_q[PIPE_STAGES-1] : '0;
    assign out_tag   = vld_q[PIPE_STAGES-1] ? tag_q[PIPE_STAGES-1] : '0;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_aes_last_round_pipe.sv
// Scoreboard bench for aes_last_round_pipe: table-based AES last-round model, directed and random traffic.
module tb_aes_last_round_pipe;
    localparam int PIPE_STAGES = 3;
    localparam int TAG_W       = 4;

    logic             clk, rst_n, flush, in_valid, in_ready, in_dec, out_valid, out_ready, busy;
    logic [127:0]     in_state, in_key, out_state;
    logic [TAG_W-1:0] in_tag, out_tag;

    aes_last_round_pipe #(.PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
        .in_state(in_state), .in_key(in_key), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_tag(out_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]     st;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t     sb[$];
    int       pop_cyc[$];
    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       stalls = 0;
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // S-box from the multiply-by-3 / divide-by-3 walk over GF(2^8), then the affine map.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fwd_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key, input logic dec);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] r;
        for (int n = 0; n < 16; n++) a[n] = st[127-8*n -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                if (!dec) b[row+4*c] = fwd_t[a[row+4*((c+row)%4)]];
                else      b[row+4*((c+row)%4)] = inv_t[a[row+4*c]];
            end
        end
        for (int n = 0; n < 16; n++) r[127-8*n -: 8] = b[n];
        return r ^ key;
    endfunction

    // Call just after a falling edge; returns one falling edge after the accepting rising edge.
    task automatic send(input logic [127:0] st, input logic [127:0] key, input logic dec, input logic [TAG_W-1:0] tag);
        int   guard;
        exp_t e;
        guard    = 0;
        in_valid = 1'b1;
        in_state = st;
        in_key   = key;
        in_dec   = dec;
        in_tag   = tag;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        stalls += guard;
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end else begin
            e.st  = ref_round(st, key, dec);
            e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while ((sb.size() != 0 || busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check(name, 128'(sb.size()), 128'd0);
        @(negedge clk);
    endtask

    // Monitor samples one time unit before each rising edge.
    logic             held = 1'b0;
    logic [127:0]     h_st;
    logic [TAG_W-1:0] h_tag;
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        cyc++;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 128'(out_valid), 128'd1);
                check("hold_state", out_state, h_st);
                check("hold_tag", 128'(out_tag), 128'(h_tag));
            end
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got state %h tag %h, required no output", out_state, out_tag);
                end else begin
                    e = sb.pop_front();
                    check("out_state", out_state, e.st);
                    check("out_tag", 128'(out_tag), 128'(e.tag));
                    pop_cyc.push_back(cyc);
                end
            end
            held  = out_valid && !out_ready && !flush;
            h_st  = out_state;
            h_tag = out_tag;
        end
    end

    localparam logic [127:0] V1S = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] V1K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] V1R = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2S = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] V2K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2R = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int   lat;
        logic rand_done;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_dec = 1'b0;
        in_state = '0; in_key = '0; in_tag = '0; out_ready = 1'b1;
        build_tables();
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_out_tag", 128'(out_tag), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 128'(in_ready), 128'd1);

        // Known encrypt vector with latency measurement
        send(V1S, V1K, 1'b0, 4'h1);
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check("enc_latency", 128'(lat), 128'(PIPE_STAGES));
        check("enc_vector", out_state, V1R);
        wait_drain("enc_drain");

        // Known decrypt vector
        send(V2S, V2K, 1'b1, 4'h2);
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check("dec_latency", 128'(lat), 128'(PIPE_STAGES));
        check("dec_vector", out_state, V2R);
        wait_drain("dec_drain");

        // Back-to-back alternating stream
        stalls = 0;
        for (int i = 0; i < 8; i++)
            send((i % 2) ? {16{8'h63}} : 128'd0, 128'd0, 1'(i % 2), TAG_W'(i));
        check("stream_no_stall", 128'(stalls), 128'd0);
        wait_drain("stream_drain");
        check("stream_one_per_cycle", 128'(pop_cyc[$] - pop_cyc[$-7]), 128'd7);

        // Fill with downstream stalled, hold, then release
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send({$urandom(), $urandom(), $urandom(), $urandom()},
                 {$urandom(), $urandom(), $urandom(), $urandom()}, 1'(i % 2), TAG_W'(8 + i));
        in_valid = 1'b1;
        in_state = {4{32'hdeadbeef}};
        in_key   = '0;
        in_dec   = 1'b0;
        in_tag   = 4'hb;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("full_in_ready", 128'(in_ready), 128'd0);
            check("full_out_valid", 128'(out_valid), 128'd1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send({4{32'hdeadbeef}}, 128'd0, 1'b0, 4'hb);
        wait_drain("release_drain");

        // Random traffic with random downstream back-pressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send({$urandom(), $urandom(), $urandom(), $urandom()},
                         {$urandom(), $urandom(), $urandom(), $urandom()},
                         1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("random_drain");

        // Flush with two blocks in flight and a competing input
        send(V1S, V1K, 1'b0, 4'h3);
        send(V2S, V2K, 1'b1, 4'h4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_state = V1S;
        in_key   = V1K;
        in_tag   = 4'h5;
        #1;
        check("flush_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_busy", 128'(busy), 128'd0);
        check("flush_out_valid", 128'(out_valid), 128'd0);
`ifdef AES_LR_SECURE_CLEAR_EN
        check("flush_out_state", out_state, 128'd0);
`endif
        repeat (5) @(negedge clk);
        check("flush_still_idle", 128'(busy), 128'd0);

        // Asynchronous reset with a result waiting at the output
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(V2S, V2K, 1'b1, TAG_W'(i));
        check("pre_reset_out_valid", 128'(out_valid), 128'd1);
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(V1S, V1K, 1'b0, 4'h6);
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check("post_reset_vector", out_state, V1R);
        wait_drain("post_reset_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
